// File: rtl/icache_direct_pkg.sv
// Shared definitions for the direct-mapped instruction cache: FSM state
// encoding and the instruction word width.
package icache_direct_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_READ = 2'd1,
        UPDATE   = 2'd2
    } icache_state_e;

endpackage

// File: rtl/icache_direct_line_array.sv
// Valid/tag/data storage for the cache. Reads are asynchronous on the
// selected line; writes happen on the refill cycle. Flush and reset clear
// every valid bit, and flush wins over a simultaneous refill write.
module icache_direct_line_array
    import icache_direct_pkg::*;
#(
    parameter int NUM_LINES   = 8,
    parameter int TAG_W       = 3,
    parameter int BLOCK_WORDS = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            flush,
    input  logic [$clog2(NUM_LINES)-1:0]    rd_idx,
    output logic                            rd_valid,
    output logic [TAG_W-1:0]                rd_tag,
    output logic [WORD_W*BLOCK_WORDS-1:0]   rd_block,
    input  logic                            wr_en,
    input  logic [$clog2(NUM_LINES)-1:0]    wr_idx,
    input  logic [TAG_W-1:0]                wr_tag,
    input  logic [WORD_W*BLOCK_WORDS-1:0]   wr_block,
    input  logic                            wr_valid
);

    logic [NUM_LINES-1:0]          valid_q;
    logic [TAG_W-1:0]              tag_mem  [NUM_LINES];
    logic [WORD_W*BLOCK_WORDS-1:0] data_mem [NUM_LINES];

    // Valid bits: cleared by reset or flush, otherwise set/cleared by a refill
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= wr_valid;
        end
    end

    // Tag and data storage; contents are don't-care until the line is valid
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_block;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_block = data_mem[rd_idx];

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped, read-only instruction cache. Hits return the word in the
// same cycle; misses stall the fetch port, read one block from instruction
// memory, write it in a single UPDATE cycle and then replay as a hit.
module icache_direct
    import icache_direct_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int NUM_LINES   = 8,
    parameter int BLOCK_WORDS = 4,
    parameter int COUNT_W     = 16
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 read,
    input  logic [ADDR_W-1:0]                    address,
    output logic [WORD_W-1:0]                    readdata,
    output logic                                 busywait,
    input  logic                                 flush,
    output logic                                 mem_read,
    output logic [ADDR_W-$clog2(BLOCK_WORDS)-3:0] mem_address,
    input  logic [WORD_W*BLOCK_WORDS-1:0]        mem_readdata,
    input  logic                                 mem_busywait,
    output logic [COUNT_W-1:0]                   hit_count,
    output logic [COUNT_W-1:0]                   miss_count
);

    localparam int OFF_W     = $clog2(BLOCK_WORDS);
    localparam int OFF_SEL_W = (OFF_W > 0) ? OFF_W : 1;
    localparam int IDX_W     = $clog2(NUM_LINES);
    localparam int TAG_W     = ADDR_W - 2 - OFF_W - IDX_W;
    localparam int BLOCK_W   = WORD_W * BLOCK_WORDS;

    icache_state_e        state_q, state_d;
    logic [IDX_W-1:0]     miss_idx_q, miss_idx_d;
    logic [TAG_W-1:0]     miss_tag_q, miss_tag_d;
    logic [BLOCK_W-1:0]   fill_q, fill_d;
    logic                 fill_kill_q, fill_kill_d;
    logic [WORD_W-1:0]    readdata_q;
    logic [COUNT_W-1:0]   hit_count_q, miss_count_q;

    logic [IDX_W-1:0]     addr_idx;
    logic [TAG_W-1:0]     addr_tag;
    logic [OFF_SEL_W-1:0] word_off;
    logic                 line_valid;
    logic [TAG_W-1:0]     line_tag;
    logic [BLOCK_W-1:0]   line_block;
    logic [WORD_W-1:0]    line_words [BLOCK_WORDS];
    logic                 hit, idle_hit, miss_start;
    logic                 busy_c, mem_read_c;
    logic                 unused_byte_bits;

    // The two byte-select bits never matter for word fetches
    assign unused_byte_bits = ^address[1:0];

    assign addr_idx = address[OFF_W+2 +: IDX_W];
    assign addr_tag = address[ADDR_W-1 -: TAG_W];

    genvar gi;
    generate
        if (OFF_W > 0) begin : g_off
            assign word_off = address[OFF_W+1:2];
        end else begin : g_no_off
            assign word_off = 1'b0;
        end
        for (gi = 0; gi < BLOCK_WORDS; gi++) begin : g_words
            assign line_words[gi] = line_block[gi*WORD_W +: WORD_W];
        end
    endgenerate

    icache_direct_line_array #(
        .NUM_LINES   (NUM_LINES),
        .TAG_W       (TAG_W),
        .BLOCK_WORDS (BLOCK_WORDS)
    ) u_lines (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .rd_idx   (addr_idx),
        .rd_valid (line_valid),
        .rd_tag   (line_tag),
        .rd_block (line_block),
        .wr_en    (state_q == UPDATE),
        .wr_idx   (miss_idx_q),
        .wr_tag   (miss_tag_q),
        .wr_block (fill_q),
        .wr_valid (!fill_kill_q)
    );

    assign hit        = line_valid && (line_tag == addr_tag);
    assign idle_hit   = (state_q == IDLE) && read && hit;
    assign miss_start = (state_q == IDLE) && read && !hit;

    // Next-state, miss capture, refill capture and handshake outputs
    always_comb begin
        state_d     = state_q;
        miss_idx_d  = miss_idx_q;
        miss_tag_d  = miss_tag_q;
        fill_d      = fill_q;
        fill_kill_d = fill_kill_q;
        busy_c      = 1'b0;
        mem_read_c  = 1'b0;
        case (state_q)
            IDLE: begin
                fill_kill_d = 1'b0;
                if (read && !hit) begin
                    busy_c     = 1'b1;
                    miss_idx_d = addr_idx;
                    miss_tag_d = addr_tag;
                    state_d    = MEM_READ;
                end
            end
            MEM_READ: begin
                busy_c     = 1'b1;
                mem_read_c = 1'b1;
                if (flush) begin
                    fill_kill_d = 1'b1;
                end
                if (!mem_busywait) begin
                    fill_d  = mem_readdata;
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                // A flush here is handled by the line array's flush priority
                busy_c      = 1'b1;
                fill_kill_d = 1'b0;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM and miss-path registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            miss_idx_q  <= '0;
            miss_tag_q  <= '0;
            fill_q      <= '0;
            fill_kill_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            miss_idx_q  <= miss_idx_d;
            miss_tag_q  <= miss_tag_d;
            fill_q      <= fill_d;
            fill_kill_q <= fill_kill_d;
        end
    end

    // Last delivered instruction, held while not fetching or stalled
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            readdata_q <= '0;
        end else if (idle_hit) begin
            readdata_q <= line_words[word_off];
        end
    end

    // Performance counters; both stop at all-ones
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            if (idle_hit && (hit_count_q != '1)) begin
                hit_count_q <= hit_count_q + COUNT_W'(1);
            end
            if (miss_start && (miss_count_q != '1)) begin
                miss_count_q <= miss_count_q + COUNT_W'(1);
            end
        end
    end

    // Reset forces busywait low even though read may be high meanwhile
    assign busywait    = reset && busy_c;
    assign mem_read    = mem_read_c;
    assign mem_address = {miss_tag_q, miss_idx_q};
    assign readdata    = idle_hit ? line_words[word_off] : readdata_q;
    assign hit_count   = hit_count_q;
    assign miss_count  = miss_count_q;

endmodule
